edge_delay_filter_array: RTL and testbench
==========================================

Name: edge_delay_filter_array

Overview:
- Multi-channel successor to the single-channel edge delay detect/hold blocks.
- Each of CHANNELS inputs gets its own debounce delay, polarity, enable, force and mode:
  - hold mode: stretched level plus rise/fall pulses;
  - trigger mode: one pulse per qualified assertion.
- Per-channel sticky event flags and a maskable combined interrupt let the block sit between GPIO/key pads and the APB peripheral register file.

Parameters:
CHANNELS, 8, number of independent channels
WIDTH, 4, delay counter width; max delay 2^WIDTH-1 cycles

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
din_i  in  CHANNELS  raw inputs, already synchronised to clk
en_i  in  CHANNELS  per-channel enable
pol_i  in  CHANNELS  expected (active) level per channel
mode_i  in  CHANNELS  0 = hold mode, 1 = trigger mode
force_i  in  CHANNELS  treat channel as matching regardless of din_i
delay_i  in  CHANNELS*WIDTH  per-channel delay D; channel i uses bits [i*WIDTH +: WIDTH]
irq_en_i  in  CHANNELS  interrupt mask
evt_clr_i  in  CHANNELS  one-cycle clear strobe for sticky flags
valid_o  out  CHANNELS  hold mode: filtered level; trigger mode: 1-cycle trigger pulse
rise_o  out  CHANNELS  1-cycle pulse when valid_o rises (hold mode only)
fall_o  out  CHANNELS  1-cycle pulse when valid_o falls (hold mode only)
evt_o  out  CHANNELS  sticky event flags
irq_o  out  1  |(evt_o & irq_en_i), registered

Behaviour:
- Definition: match[i] = force_i[i] | (din_i[i] == pol_i[i]).
- All outputs are registered. On rst, every state is IDLE, every counter is 0, and valid_o, rise_o, fall_o, evt_o and irq_o are 0.
- Reset is synchronous and active-high, and wins over all other inputs in the same cycle.
- Each channel has a 4-state FSM and a WIDTH-bit counter cnt.
- FSM states and transitions:
  - IDLE: cnt=0.
    - If en & match and D==0: go to ACTIVE.
    - If en & match and D>0: go to QUALIFY with cnt=1.
  - QUALIFY:
    - If mismatch or !en: go to IDLE, cnt=0.
    - Else if cnt >= D: go to ACTIVE, cnt=0.
    - Else: cnt+1.
  - ACTIVE: valid is asserted.
    - Hold mode: on mismatch, go to RELEASE with cnt=1 if D>0; if D==0, go directly to IDLE.
    - Trigger mode: stay in ACTIVE, with valid_o low after the first cycle, until mismatch; then go to IDLE. There is no retrigger while the input is held.
  - RELEASE (hold mode only):
    - On match: return to ACTIVE, cnt=0; valid stays high with no pulses.
    - Else if cnt >= D: go to IDLE.
    - Else: cnt+1.
- Timing:
  - Assert latency: match sampled on D+1 consecutive edges -> valid_o high after the (D+1)th edge. D=0 gives 1-cycle latency.
  - Hold mode release: valid_o stays high until mismatch has been sampled on D+1 consecutive edges. The output pulse width therefore equals the input width.
- Comparisons use >=, so a delay_i change mid-count never deadlocks; a reduced D qualifies on the next edge.
- Trigger pulse: valid_o is high for exactly one cycle on entry to ACTIVE.
- rise_o and fall_o coincide with the valid_o transitions, in hold mode only. In trigger mode both stay 0.
- en_i low: the channel goes to IDLE on the next edge and valid_o drops. No fall_o is generated and evt_o is not set.
- mode_i change: allowed only while en_i=0; otherwise behaviour is undefined.
- evt_o[i] is set on rise_o (hold mode) or on the trigger pulse (trigger mode). It is cleared by evt_clr_i[i]. If set and clear occur in the same cycle, set wins.
- irq_o lags evt_o/irq_en_i by one cycle.
- Channels are fully independent; no shared arbitration.

Test Plan:
1. Hold mode, D=3, pol=1: din high for 10 cycles -> valid_o high 4 cycles after the rise, high for 10 cycles, then low. rise_o and fall_o each pulse once; evt_o[0]=1.
2. Glitch rejection, D=3: din high for 3 cycles, then low -> valid_o, rise_o and evt_o stay 0. Release glitch: while ACTIVE, din low for 2 cycles -> valid_o stays high with no fall_o.
3. Trigger mode, D=2: din high for 20 cycles -> exactly one valid_o pulse 3 cycles after the rise. Dropping din for 3 cycles and raising it again -> a second pulse.
4. D=0 with force_i=1 and din=0 -> valid_o high after 1 cycle. Deassert force -> valid_o low after 1 cycle.
5. Event/interrupt: evt_clr_i asserted in the same cycle as the set -> evt_o stays 1. A later clear -> 0. irq_o follows one cycle later, and only with irq_en_i=1.
6. Disable and reset mid-operation:
   - Deassert en_i while in ACTIVE -> valid_o=0 next cycle, no fall_o.
   - Assert rst in QUALIFY on channels 0 and 7 simultaneously -> all outputs 0 next cycle.
   - After reset, a full D+1 qualification is required before valid_o asserts.

Source files
------------

// File: rtl/edge_delay_filter_array.sv
// Multi-channel edge delay filter: per-channel debounce, hold/trigger modes,
// sticky event flags and a maskable registered interrupt.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for an enabled match, cnt held at 0
// QUALIFY | counting consecutive matched edges towards the delay
// ACTIVE  | qualified; hold: level high, trigger: pulsed once, waiting
// RELEASE | hold mode only: counting consecutive mismatched edges
module edge_delay_filter_array #(
  parameter int CHANNELS = 8,
  parameter int WIDTH    = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [CHANNELS-1:0]       din_i,
  input  logic [CHANNELS-1:0]       en_i,
  input  logic [CHANNELS-1:0]       pol_i,
  input  logic [CHANNELS-1:0]       mode_i,
  input  logic [CHANNELS-1:0]       force_i,
  input  logic [CHANNELS*WIDTH-1:0] delay_i,
  input  logic [CHANNELS-1:0]       irq_en_i,
  input  logic [CHANNELS-1:0]       evt_clr_i,
  output logic [CHANNELS-1:0]       valid_o,
  output logic [CHANNELS-1:0]       rise_o,
  output logic [CHANNELS-1:0]       fall_o,
  output logic [CHANNELS-1:0]       evt_o,
  output logic                      irq_o
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_QUALIFY = 2'd1,
    S_ACTIVE  = 2'd2,
    S_RELEASE = 2'd3
  } state_t;

  localparam logic [WIDTH-1:0] CNT_ONE = WIDTH'(1);

  logic irq_q;

  for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
    state_t           state_q, state_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] dly;
    logic             match;
    logic             hold;
    logic             valid_q, valid_d;
    logic             rise_q, rise_d;
    logic             fall_q, fall_d;
    logic             evt_q, evt_d;
    logic             set_evt;

    assign dly   = delay_i[gi*WIDTH +: WIDTH];
    assign match = force_i[gi] | (din_i[gi] == pol_i[gi]);
    assign hold  = ~mode_i[gi];

    // Next-state and counter: disable overrides everything; >= compares keep
    // a mid-count delay reduction from stalling.
    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      if (!en_i[gi]) begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end else begin
        case (state_q)
          S_IDLE: begin
            cnt_d = '0;
            if (match) begin
              if (dly == '0) begin
                state_d = S_ACTIVE;
              end else begin
                state_d = S_QUALIFY;
                cnt_d   = CNT_ONE;
              end
            end
          end
          S_QUALIFY: begin
            if (!match) begin
              state_d = S_IDLE;
              cnt_d   = '0;
            end else if (cnt_q >= dly) begin
              state_d = S_ACTIVE;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
          S_ACTIVE: begin
            cnt_d = '0;
            if (!match) begin
              if (!hold || dly == '0) begin
                state_d = S_IDLE;
              end else begin
                state_d = S_RELEASE;
                cnt_d   = CNT_ONE;
              end
            end
          end
          S_RELEASE: begin
            if (!hold) begin
              state_d = S_IDLE;
              cnt_d   = '0;
            end else if (match) begin
              state_d = S_ACTIVE;
              cnt_d   = '0;
            end else if (cnt_q >= dly) begin
              state_d = S_IDLE;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
          default: begin
            state_d = S_IDLE;
            cnt_d   = '0;
          end
        endcase
      end
    end

    // Output decode from the next state so every output is registered
    // alongside the state it describes; a disable drop never makes fall.
    always_comb begin
      valid_d = 1'b0;
      rise_d  = 1'b0;
      fall_d  = 1'b0;
      set_evt = 1'b0;
      if (hold) begin
        valid_d = (state_d == S_ACTIVE) || (state_d == S_RELEASE);
        rise_d  = valid_d & ~valid_q;
        fall_d  = en_i[gi] & valid_q & ~valid_d;
        set_evt = rise_d;
      end else begin
        valid_d = (state_d == S_ACTIVE) && (state_q != S_ACTIVE);
        set_evt = valid_d;
      end
      evt_d = set_evt | (evt_q & ~evt_clr_i[gi]);
    end

    // Channel state, counter and registered outputs.
    always_ff @(posedge clk) begin
      if (rst) begin
        state_q <= S_IDLE;
        cnt_q   <= '0;
        valid_q <= 1'b0;
        rise_q  <= 1'b0;
        fall_q  <= 1'b0;
        evt_q   <= 1'b0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        valid_q <= valid_d;
        rise_q  <= rise_d;
        fall_q  <= fall_d;
        evt_q   <= evt_d;
      end
    end

    assign valid_o[gi] = valid_q;
    assign rise_o[gi]  = rise_q;
    assign fall_o[gi]  = fall_q;
    assign evt_o[gi]   = evt_q;
  end

  // Interrupt is the masked OR of the current sticky flags, one cycle late.
  always_ff @(posedge clk) begin
    if (rst) begin
      irq_q <= 1'b0;
    end else begin
      irq_q <= |(evt_o & irq_en_i);
    end
  end

  assign irq_o = irq_q;

endmodule

// File: tb/tb_edge_delay_filter_array.sv
// Bench for edge_delay_filter_array: directed scenarios with literal
// expectations, then randomized traffic, all checked each cycle against a
// run-length reference model.
module tb_edge_delay_filter_array;

  localparam int CH = 8;
  localparam int W  = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic [CH-1:0]   din, en, pol, mode, force_v, irq_en, evt_clr;
  logic [CH*W-1:0] delay_v;
  logic [CH-1:0]   valid_o, rise_o, fall_o, evt_o;
  logic            irq_o;

  edge_delay_filter_array #(.CHANNELS(CH), .WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .din_i     (din),
    .en_i      (en),
    .pol_i     (pol),
    .mode_i    (mode),
    .force_i   (force_v),
    .delay_i   (delay_v),
    .irq_en_i  (irq_en),
    .evt_clr_i (evt_clr),
    .valid_o   (valid_o),
    .rise_o    (rise_o),
    .fall_o    (fall_o),
    .evt_o     (evt_o),
    .irq_o     (irq_o)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  bit chk_on = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Reference model: counts consecutive matched / mismatched enabled edges.
  logic [CH-1:0] m_valid, m_rise, m_fall, m_evt;
  logic          m_irq;
  int            run_m [CH];
  int            run_x [CH];
  bit            fired [CH];

  always @(posedge clk) begin : model
    int   d;
    logic mt, pv, nv, st;
    logic [CH-1:0] old_evt;
    if (rst) begin
      m_valid = '0; m_rise = '0; m_fall = '0; m_evt = '0; m_irq = 1'b0;
      for (int i = 0; i < CH; i++) begin
        run_m[i] = 0; run_x[i] = 0; fired[i] = 1'b0;
      end
    end else begin
      old_evt = m_evt;
      m_irq   = |(old_evt & irq_en);
      for (int i = 0; i < CH; i++) begin
        d  = int'(delay_v[i*W +: W]);
        mt = force_v[i] | (din[i] == pol[i]);
        pv = m_valid[i];
        nv = 1'b0;
        st = 1'b0;
        m_rise[i] = 1'b0;
        m_fall[i] = 1'b0;
        if (!en[i]) begin
          run_m[i] = 0; run_x[i] = 0; fired[i] = 1'b0;
        end else if (!mode[i]) begin
          if (!pv) begin
            run_m[i] = mt ? run_m[i] + 1 : 0;
            nv = mt && (run_m[i] - 1 >= d);
            run_x[i] = 0;
          end else begin
            run_x[i] = mt ? 0 : run_x[i] + 1;
            nv = !(!mt && (run_x[i] - 1 >= d));
            run_m[i] = 0;
          end
          m_rise[i] = nv & ~pv;
          m_fall[i] = pv & ~nv;
          st = m_rise[i];
        end else begin
          if (!mt) begin
            run_m[i] = 0; fired[i] = 1'b0;
          end else begin
            run_m[i]++;
            if (!fired[i] && (run_m[i] - 1 >= d)) begin
              nv = 1'b1; fired[i] = 1'b1;
            end
          end
          st = nv;
        end
        m_valid[i] = nv;
        m_evt[i]   = st | (old_evt[i] & ~evt_clr[i]);
      end
    end
  end

  // Compare DUT against the model every cycle, away from the active edge.
  always @(negedge clk) begin
    if (chk_on) begin
      chk("valid", 32'(valid_o), 32'(m_valid));
      chk("rise",  32'(rise_o),  32'(m_rise));
      chk("fall",  32'(fall_o),  32'(m_fall));
      chk("evt",   32'(evt_o),   32'(m_evt));
      chk("irq",   32'(irq_o),   32'(m_irq));
    end
  end

  int pulses, at;

  initial begin
    rst = 1'b1; din = '0; en = '0; pol = '1; mode = '0; force_v = '0;
    irq_en = '0; evt_clr = '0; delay_v = '0;
    tick(2);
    chk_on = 1'b1;
    chk("reset_outs", {valid_o, rise_o, fall_o, evt_o, 7'd0, irq_o}, 32'd0);
    rst = 1'b0;

    // 1: hold mode, D=3, 10-cycle input
    delay_v[0*W +: W] = 4'd3; en[0] = 1'b1; tick(1);
    din[0] = 1'b1;
    tick(3); chk("t1_pre", 32'(valid_o[0]), 32'd0);
    tick(1); chk("t1_rise", 32'({valid_o[0], rise_o[0]}), 32'd3);
    tick(6); din[0] = 1'b0;
    tick(3); chk("t1_hold", 32'(valid_o[0]), 32'd1);
    tick(1); chk("t1_fall", 32'({valid_o[0], fall_o[0]}), 32'd1);
    chk("t1_evt", 32'(evt_o[0]), 32'd1);
    evt_clr[0] = 1'b1; tick(1); evt_clr[0] = 1'b0;
    chk("t1_clr", 32'(evt_o[0]), 32'd0);

    // 2: glitch rejection and release glitch
    din[0] = 1'b1; tick(3); din[0] = 1'b0; tick(5);
    chk("t2_glitch", 32'({valid_o[0], evt_o[0]}), 32'd0);
    din[0] = 1'b1; tick(4);
    chk("t2_act", 32'(valid_o[0]), 32'd1);
    tick(2); din[0] = 1'b0; tick(2); din[0] = 1'b1; tick(3);
    chk("t2_relglitch", 32'(valid_o[0]), 32'd1);
    din[0] = 1'b0; tick(4);
    chk("t2_drop", 32'(valid_o[0]), 32'd0);

    // 3: trigger mode, D=2
    en[0] = 1'b0; tick(1);
    mode[0] = 1'b1; delay_v[0*W +: W] = 4'd2; tick(1);
    en[0] = 1'b1; din[0] = 1'b1;
    pulses = 0; at = 0;
    for (int k = 1; k <= 20; k++) begin
      tick(1);
      if (valid_o[0]) begin pulses++; at = k; end
    end
    chk("t3_pulses", 32'(pulses), 32'd1);
    chk("t3_at", 32'(at), 32'd3);
    din[0] = 1'b0; tick(3); din[0] = 1'b1;
    pulses = 0; at = 0;
    for (int k = 1; k <= 10; k++) begin
      tick(1);
      if (valid_o[0]) begin pulses++; at = k; end
    end
    chk("t3_second", 32'(pulses), 32'd1);
    chk("t3_second_at", 32'(at), 32'd3);
    en[0] = 1'b0; din[0] = 1'b0; tick(1);
    mode[0] = 1'b0; evt_clr[0] = 1'b1; tick(1); evt_clr[0] = 1'b0;

    // 4: D=0 with force
    en[1] = 1'b1; force_v[1] = 1'b1; tick(1);
    chk("t4_force_on", 32'(valid_o[1]), 32'd1);
    force_v[1] = 1'b0; tick(1);
    chk("t4_force_off", 32'(valid_o[1]), 32'd0);

    // 5: event set/clear collision and interrupt
    irq_en[2] = 1'b1; en[2] = 1'b1; tick(1);
    din[2] = 1'b1; evt_clr[2] = 1'b1; tick(1); evt_clr[2] = 1'b0;
    chk("t5_setwins", 32'(evt_o[2]), 32'd1);
    tick(1); chk("t5_irq_on", 32'(irq_o), 32'd1);
    evt_clr[2] = 1'b1; tick(1); evt_clr[2] = 1'b0;
    chk("t5_clr", 32'({evt_o[2], irq_o}), 32'd1);
    tick(1); chk("t5_irq_off", 32'(irq_o), 32'd0);
    en[3] = 1'b1; din[3] = 1'b1; tick(1);
    chk("t5_evt3", 32'(evt_o[3]), 32'd1);
    tick(2); chk("t5_masked", 32'(irq_o), 32'd0);

    // 6: disable and reset mid-operation
    delay_v[0*W +: W] = 4'd3; en[0] = 1'b1; din[0] = 1'b1; tick(4);
    chk("t6_act", 32'(valid_o[0]), 32'd1);
    en[0] = 1'b0; tick(1);
    chk("t6_dis", 32'({valid_o[0], fall_o[0], evt_o[0]}), 32'd1);
    din[0] = 1'b0; en[0] = 1'b1; tick(1);
    delay_v[7*W +: W] = 4'd3; din[0] = 1'b1; din[7] = 1'b1; en[7] = 1'b1; tick(2);
    rst = 1'b1; tick(1); rst = 1'b0;
    chk("t6_rst", {valid_o, rise_o, fall_o, evt_o, 7'd0, irq_o}, 32'd0);
    tick(3); chk("t6_requal_pre", 32'({valid_o[7], valid_o[0]}), 32'd0);
    tick(1); chk("t6_requal", 32'({valid_o[7], valid_o[0]}), 32'd3);

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(0, 499) == 0);
      for (int i = 0; i < CH; i++) begin
        if ($urandom_range(0, i + 1) == 0) din[i] = ~din[i];
        if (!en[i] && $urandom_range(0, 7) == 0) mode[i] = ~mode[i];
        else if ($urandom_range(0, 39) == 0) en[i] = ~en[i];
        if ($urandom_range(0, 59) == 0)
          delay_v[i*W +: W] = ($urandom_range(0, 9) == 0) ? W'($urandom_range(0, 15))
                                                          : W'($urandom_range(0, 4));
        force_v[i] = ($urandom_range(0, 29) == 0);
        if ($urandom_range(0, 199) == 0) pol[i] = ~pol[i];
      end
      evt_clr = CH'($urandom & $urandom & $urandom);
      if ($urandom_range(0, 49) == 0) irq_en = CH'($urandom);
      tick(1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
